blink_bank: RTL and testbench

BLINK_BANK -- requirements
Module: blink_bank

---
 rtl/blink_bank_if.sv | 28 ++
 rtl/blink_bank.sv | 148 ++++++++++++++
 tb/tb_blink_bank.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/blink_bank_if.sv
// Configuration and status bundle for blink_bank: one write port plus the
// per-channel blink and completion outputs.
interface blink_bank_if #(
    parameter int CH = 4,
    parameter int CW = 20,
    parameter int NW = 4
);
    localparam int AW = (CH > 1) ? $clog2(CH) : 1;

    logic          cfg_we;
    logic [AW-1:0] cfg_ch;
    logic [1:0]    cfg_mode;
    logic [CW-1:0] cfg_on;
    logic [CW-1:0] cfg_off;
    logic [NW-1:0] cfg_shots;
    logic [CH-1:0] out;
    logic [CH-1:0] done;

    modport master (
        output cfg_we, cfg_ch, cfg_mode, cfg_on, cfg_off, cfg_shots,
        input  out, done
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_mode, cfg_on, cfg_off, cfg_shots,
        output out, done
    );
endinterface

// File: rtl/blink_bank.sv
// Bank of CH independent blink channels: off / steady / continuous / N-shot,
// each with programmable on and off phase lengths.
//
//   state | meaning
//   IDLE  | output low, waiting for a write
//   HOLD  | output steadily high, waiting for a write
//   ON    | on phase of a blink period, cnt counts up to on_last
//   OFF   | off phase of a blink period, cnt counts up to off_last
module blink_bank #(
    parameter int CH      = 4,
    parameter int CW      = 20,
    parameter int NW      = 4,
    parameter int RST_ON  = 155000,
    parameter int RST_OFF = 155000
) (
    input  logic         clk,
    input  logic         reset,
    blink_bank_if.slave  bus
);
    localparam int AW = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [CW-1:0] RST_ON_LAST  = (RST_ON  > 0) ? CW'(RST_ON  - 1) : '0;
    localparam logic [CW-1:0] RST_OFF_LAST = (RST_OFF > 0) ? CW'(RST_OFF - 1) : '0;

    typedef enum logic [1:0] {IDLE, HOLD, ON, OFF} state_t;

    state_t        st_q       [CH];
    state_t        st_n       [CH];
    logic [CW-1:0] cnt_q      [CH];
    logic [CW-1:0] cnt_n      [CH];
    logic [1:0]    mode_q     [CH];
    logic [1:0]    mode_n     [CH];
    logic [CW-1:0] on_last_q  [CH];
    logic [CW-1:0] on_last_n  [CH];
    logic [CW-1:0] off_last_q [CH];
    logic [CW-1:0] off_last_n [CH];
    logic [NW-1:0] shots_q    [CH];
    logic [NW-1:0] shots_n    [CH];
    logic [CH-1:0] out_q, out_n;
    logic [CH-1:0] done_q, done_n;
    logic          ch_ok;

    // Phase lengths are stored as their terminal count (length-1), so a
    // programmed length of 0 collapses onto the same terminal as length 1.
    logic [CW-1:0] wr_on_last, wr_off_last;
    logic [NW-1:0] wr_shots;
    state_t        wr_state;

    generate
        if (CH == (1 << AW)) begin : g_full_range
            assign ch_ok = 1'b1;
        end else begin : g_part_range
            assign ch_ok = (32'(bus.cfg_ch) < 32'(CH));
        end
    endgenerate

    always_comb begin
        wr_on_last  = (bus.cfg_on  == '0) ? '0 : bus.cfg_on  - CW'(1);
        wr_off_last = (bus.cfg_off == '0) ? '0 : bus.cfg_off - CW'(1);
        wr_shots    = (bus.cfg_shots == '0) ? NW'(1) : bus.cfg_shots;
        case (bus.cfg_mode)
            2'b00:   wr_state = IDLE;
            2'b01:   wr_state = HOLD;
            default: wr_state = ON;
        endcase
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            st_n[i]       = st_q[i];
            cnt_n[i]      = cnt_q[i];
            mode_n[i]     = mode_q[i];
            on_last_n[i]  = on_last_q[i];
            off_last_n[i] = off_last_q[i];
            shots_n[i]    = shots_q[i];
            done_n[i]     = 1'b0;

            case (st_q[i])
                ON: begin
                    if (cnt_q[i] == on_last_q[i]) begin
                        st_n[i]  = OFF;
                        cnt_n[i] = '0;
                    end else begin
                        cnt_n[i] = cnt_q[i] + CW'(1);
                    end
                end
                OFF: begin
                    if (cnt_q[i] == off_last_q[i]) begin
                        cnt_n[i] = '0;
                        if (mode_q[i] == 2'b11 && shots_q[i] <= NW'(1)) begin
                            st_n[i]   = IDLE;
                            done_n[i] = 1'b1;
                        end else begin
                            st_n[i] = ON;
                            if (mode_q[i] == 2'b11)
                                shots_n[i] = shots_q[i] - NW'(1);
                        end
                    end else begin
                        cnt_n[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: ;
            endcase

            // A write always wins over whatever the channel was about to do,
            // including a terminal event that would have raised done.
            if (bus.cfg_we && ch_ok && bus.cfg_ch == AW'(i)) begin
                st_n[i]       = wr_state;
                cnt_n[i]      = '0;
                mode_n[i]     = bus.cfg_mode;
                on_last_n[i]  = wr_on_last;
                off_last_n[i] = wr_off_last;
                shots_n[i]    = wr_shots;
                done_n[i]     = 1'b0;
            end

            out_n[i] = (st_n[i] == HOLD) || (st_n[i] == ON);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CH; i++) begin
                st_q[i]       <= OFF;
                cnt_q[i]      <= '0;
                mode_q[i]     <= 2'b10;
                on_last_q[i]  <= RST_ON_LAST;
                off_last_q[i] <= RST_OFF_LAST;
                shots_q[i]    <= NW'(1);
            end
            out_q  <= '0;
            done_q <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                st_q[i]       <= st_n[i];
                cnt_q[i]      <= cnt_n[i];
                mode_q[i]     <= mode_n[i];
                on_last_q[i]  <= on_last_n[i];
                off_last_q[i] <= off_last_n[i];
                shots_q[i]    <= shots_n[i];
            end
            out_q  <= out_n;
            done_q <= done_n;
        end
    end

    assign bus.out  = out_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_blink_bank.sv
// Bench for blink_bank: a 4-channel and a 3-channel instance share one write
// stream; expectations come from a per-channel timeline model.
module tb_blink_bank;
    localparam int CH   = 4;
    localparam int CW   = 8;
    localparam int NW   = 4;
    localparam int RON  = 5;
    localparam int ROFF = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    blink_bank_if #(.CH(CH), .CW(CW), .NW(NW)) ifa ();
    blink_bank_if #(.CH(3),  .CW(CW), .NW(NW)) ifb ();

    assign ifb.cfg_we    = ifa.cfg_we;
    assign ifb.cfg_ch    = ifa.cfg_ch;
    assign ifb.cfg_mode  = ifa.cfg_mode;
    assign ifb.cfg_on    = ifa.cfg_on;
    assign ifb.cfg_off   = ifa.cfg_off;
    assign ifb.cfg_shots = ifa.cfg_shots;

    blink_bank #(.CH(CH), .CW(CW), .NW(NW), .RST_ON(RON), .RST_OFF(ROFF)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    blink_bank #(.CH(3), .CW(CW), .NW(NW), .RST_ON(RON), .RST_OFF(ROFF)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    // Model: each channel remembers the edge its current behaviour started
    // on and what it was told; outputs follow from elapsed cycles alone.
    longint cyc = 0;
    longint t0 [CH];
    int     md [CH];
    int     onl [CH];
    int     offl [CH];
    int     sh [CH];
    bit     rs [CH];
    bit     mvalid = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            mvalid <= 1'b1;
            for (int i = 0; i < CH; i++) begin
                t0[i] <= cyc + 1; md[i] <= 2; rs[i] <= 1'b1;
                onl[i] <= RON; offl[i] <= ROFF; sh[i] <= 1;
            end
        end else if (ifa.cfg_we) begin
            t0[ifa.cfg_ch]   <= cyc + 1;
            md[ifa.cfg_ch]   <= int'(ifa.cfg_mode);
            rs[ifa.cfg_ch]   <= 1'b0;
            onl[ifa.cfg_ch]  <= (ifa.cfg_on == 0) ? 1 : int'(ifa.cfg_on);
            offl[ifa.cfg_ch] <= (ifa.cfg_off == 0) ? 1 : int'(ifa.cfg_off);
            sh[ifa.cfg_ch]   <= (ifa.cfg_shots == 0) ? 1 : int'(ifa.cfg_shots);
        end
    end

    function automatic void model_exp(output logic [CH-1:0] eo, output logic [CH-1:0] ed);
        longint k, p, ph;
        for (int i = 0; i < CH; i++) begin
            k  = cyc - t0[i];
            p  = onl[i] + offl[i];
            ph = (k + (rs[i] ? onl[i] : 0)) % p;
            ed[i] = 1'b0;
            case (md[i])
                0: eo[i] = 1'b0;
                1: eo[i] = 1'b1;
                2: eo[i] = (ph < onl[i]);
                default: begin
                    eo[i] = (k < sh[i] * p) && (ph < onl[i]);
                    ed[i] = (k == sh[i] * p);
                end
            endcase
        end
    endfunction

    logic [CH-1:0] eo, ed;
    always @(negedge clk) begin
        if (mvalid) begin
            model_exp(eo, ed);
            chk("out_a",  8'(ifa.out),  8'(eo));
            chk("done_a", 8'(ifa.done), 8'(ed));
            chk("out_b",  8'(ifb.out),  8'(eo[2:0]));
            chk("done_b", 8'(ifb.done), 8'(ed[2:0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int mode, input int on, input int off, input int shots);
        ifa.cfg_ch    = 2'(ch);
        ifa.cfg_mode  = 2'(mode);
        ifa.cfg_on    = CW'(on);
        ifa.cfg_off   = CW'(off);
        ifa.cfg_shots = NW'(shots);
        ifa.cfg_we    = 1'b1;
        tick();
        ifa.cfg_we    = 1'b0;
    endtask

    logic [1:20] p_rst;
    logic [0:16] p_shot_o;
    logic [0:16] p_shot_d;
    int r;

    initial begin
        p_rst    = 20'b0000_11111_00000_11111_0;
        p_shot_o = 17'b11000110001100000;
        p_shot_d = 17'b00000000000000010;
        ifa.cfg_we = 1'b0; ifa.cfg_ch = '0; ifa.cfg_mode = '0;
        ifa.cfg_on = '0; ifa.cfg_off = '0; ifa.cfg_shots = '0;

        // reset held for two edges, with a write attempt that must lose
        reset = 1'b1;
        tick();
        ifa.cfg_we = 1'b1; ifa.cfg_ch = 2'd1; ifa.cfg_mode = 2'b01;
        tick();
        ifa.cfg_we = 1'b0;
        reset = 1'b0;
        chk("rst_out", 8'(ifa.out), 8'h00);
        chk("rst_done", 8'(ifa.done), 8'h00);
        for (int j = 1; j <= 20; j++) begin
            tick();
            chk("rst_blink", 8'(ifa.out), p_rst[j] ? 8'h0F : 8'h00);
            chk("rst_blink_done", 8'(ifa.done), 8'h00);
        end

        // three-shot sequence on channel 1
        wr(1, 3, 2, 3, 3);
        for (int j = 0; j <= 16; j++) begin
            if (j > 0) tick();
            chk("shot_out1", 8'(ifa.out[1]), 8'(p_shot_o[j]));
            chk("shot_done1", 8'(ifa.done[1]), 8'(p_shot_d[j]));
        end

        // steady on from an off phase, then off
        repeat (3) tick();
        chk("pre_hold_out2", 8'(ifa.out[2]), 8'h00);
        wr(2, 1, 0, 0, 0);
        for (int j = 0; j < 12; j++) begin
            if (j > 0) tick();
            chk("hold_out2", 8'(ifa.out[2]), 8'h01);
        end
        wr(2, 0, 0, 0, 0);
        for (int j = 0; j < 4; j++) begin
            if (j > 0) tick();
            chk("idle_out2", 8'(ifa.out[2]), 8'h00);
        end

        // zero lengths: toggle every cycle
        wr(0, 2, 0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            if (j > 0) tick();
            chk("toggle_out0", 8'(ifa.out[0]), (j % 2 == 0) ? 8'h01 : 8'h00);
        end

        // channel 3 does not exist on the 3-channel instance
        wr(0, 1, 1, 1, 1);
        wr(1, 1, 1, 1, 1);
        wr(2, 1, 1, 1, 1);
        wr(3, 0, 1, 1, 1);
        for (int j = 0; j < 4; j++) begin
            if (j > 0) tick();
            chk("oor_out_b", 8'(ifb.out), 8'h07);
            chk("oor_done_b", 8'(ifb.done), 8'h00);
            chk("inr_out_a3", 8'(ifa.out[3]), 8'h00);
        end

        // reset in the middle of an N-shot run
        wr(3, 3, 2, 2, 4);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_out", 8'(ifa.out), 8'h00);
        chk("midrst_done", 8'(ifa.done), 8'h00);
        for (int j = 1; j <= 12; j++) begin
            tick();
            chk("midrst_blink", 8'(ifa.out), p_rst[j] ? 8'h0F : 8'h00);
            chk("midrst_nodone", 8'(ifa.done), 8'h00);
        end

        // random traffic, occasional reset colliding with a write
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            reset         = (r < 2);
            ifa.cfg_we    = (r < 2) ? 1'($urandom_range(0, 1)) : (r < 10);
            ifa.cfg_ch    = 2'($urandom_range(0, 3));
            ifa.cfg_mode  = 2'($urandom_range(0, 3));
            ifa.cfg_on    = CW'($urandom_range(0, 6));
            ifa.cfg_off   = CW'($urandom_range(0, 6));
            ifa.cfg_shots = NW'($urandom_range(0, 4));
            tick();
        end
        reset = 1'b0;
        ifa.cfg_we = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
